// File: rtl/accumulator_ctrl_pkg.sv
// Shared types and default widths for the accumulator window sequencer.
package accumulator_ctrl_pkg;

   localparam int unsigned BITWIDTH_DEF = 8;
   localparam int unsigned CNTWIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/accumulator_ctrl_if.sv
// Request, sample-stream and result handshake bundle between the sequencer and its neighbours.
interface accumulator_ctrl_if
   import accumulator_ctrl_pkg::*;
#(
   parameter int unsigned BITWIDTH = BITWIDTH_DEF,
   parameter int unsigned CNTWIDTH = CNTWIDTH_DEF
);

   logic                iStart;
   logic [CNTWIDTH-1:0] iLen;
   logic                iAbort;
   logic                oReady;
   logic [BITWIDTH-1:0] iData;
   logic                oDataReq;
   logic                oValid;
   logic                iReady;
   logic [BITWIDTH:0]   oResult;

   modport master (
      output iStart, iLen, iAbort, iData, iReady,
      input  oReady, oDataReq, oValid, oResult
   );

   modport slave (
      input  iStart, iLen, iAbort, iData, iReady,
      output oReady, oDataReq, oValid, oResult
   );

endinterface

// File: rtl/accumulator.sv
// Running-sum datapath: clear has priority over enable; sum wraps at BITWIDTH+1 bits.
module accumulator #(
   parameter int unsigned BITWIDTH = 8
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iEn,
   input  logic                iClr,
   input  logic [BITWIDTH-1:0] iData,
   output logic [BITWIDTH:0]   oData
);

   localparam int unsigned SUMW = BITWIDTH + 1;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oData <= '0;
      end else if (iClr) begin
         oData <= '0;
      end else if (iEn) begin
         oData <= oData + SUMW'(iData);
      end
   end

endmodule

// File: rtl/accumulator_ctrl.sv
// Window sequencer: clears the accumulator, enables it for N cycles, then
// holds the sum under a valid/ready handshake until accepted or aborted.
module accumulator_ctrl
   import accumulator_ctrl_pkg::*;
#(
   parameter int unsigned BITWIDTH = BITWIDTH_DEF,
   parameter int unsigned CNTWIDTH = CNTWIDTH_DEF
) (
   input  logic         iClk,
   input  logic         iRstN,
   accumulator_ctrl_if.slave bus
);

   state_t              state;
   state_t              stateNext;
   logic [CNTWIDTH-1:0] cnt;
   logic [CNTWIDTH-1:0] cntNext;
   logic                accEn;
   logic                accClr;
   logic [BITWIDTH:0]   accOut;

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Counter holds the remaining RUN cycles; last RUN cycle is the one with cnt==1.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      accEn     = 1'b0;
      accClr    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.iStart) begin
               cntNext   = bus.iLen;
               stateNext = CLR;
            end
         end
         CLR: begin
            accClr    = 1'b1;
            stateNext = (cnt == '0) ? DONE : RUN;
         end
         RUN: begin
            accEn   = 1'b1;
            cntNext = cnt - CNTWIDTH'(1);
            if (cnt == CNTWIDTH'(1)) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            if (bus.iReady) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
      // Abort overrides start, ready and any pending accumulation.
      if (bus.iAbort) begin
         stateNext = IDLE;
         cntNext   = '0;
         accEn     = 1'b0;
         accClr    = 1'b1;
      end
   end

   accumulator #(
      .BITWIDTH (BITWIDTH)
   ) uAccumulator (
      .iClk  (iClk),
      .iRstN (iRstN),
      .iEn   (accEn),
      .iClr  (accClr),
      .iData (bus.iData),
      .oData (accOut)
   );

   assign bus.oReady   = (state == IDLE);
   assign bus.oDataReq = (state == RUN);
   assign bus.oValid   = (state == DONE);
   assign bus.oResult  = (state == DONE) ? accOut : '0;

endmodule
